pwm_demodulator: RTL and testbench



---
 rtl/pwm_demodulator_pkg.sv | 15 +
 rtl/pwm_demodulator_if.sv | 11 +
 rtl/pwm_demodulator_sample_fifo.sv | 68 ++++++
 rtl/pwm_demodulator.sv | 145 ++++++++++++++
 tb/tb_pwm_demodulator.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_demodulator_pkg.sv
// Shared types and helpers for the PWM capture path: FSM state encoding,
// nominal period and the duty-to-sample mapping used by the PWM output side.
package pwm_demodulator_pkg;

   localparam int DUTY_WIDTH_DEF = 8;
   localparam int PWM_PERIOD     = 2**DUTY_WIDTH_DEF;

   typedef enum logic [1:0] {IDLE, MEASURE, CONST} DEMOD_STATE;

   // Inverse of the streamer's sample-to-duty mapping: offset binary to two's complement.
   function automatic logic signed [15:0] DutyToSample(input logic [7:0] duty);
      return $signed({~duty[7], duty[6:0], 8'h00});
   endfunction

endpackage

// File: rtl/pwm_demodulator_if.sv
// Valid/ready sample stream from the demodulator to the controller/packetiser.
interface pwm_demodulator_if;

   logic signed [15:0] opStream;
   logic               opValid;
   logic               ipReady;

   modport master (output opStream, output opValid, input ipReady);
   modport slave  (input opStream, input opValid, output ipReady);

endinterface

// File: rtl/pwm_demodulator_sample_fifo.sv
// Show-ahead sample FIFO with occupancy and saturating drop count; depth must
// be a power of two so the pointers wrap naturally.
module sample_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 16
)(
   input  logic                     ipClk,
   input  logic                     ipReset,
   input  logic                     ipPush,
   input  logic signed [DATA_W-1:0] ipData,
   input  logic                     ipPop,
   output logic signed [DATA_W-1:0] opHead,
   output logic                     opValid,
   output logic [$clog2(DEPTH):0]   opSize,
   output logic [15:0]              opDrop
);

   localparam int AW = $clog2(DEPTH);

   logic signed [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic [AW:0]   count;
   logic [15:0]   dropCnt;
   logic          full;
   logic          doPop;
   logic          doPush;
   logic          doDrop;

   function automatic logic [15:0] satInc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign full    = (count == (AW+1)'(DEPTH));
   assign opValid = (count != '0);
   assign doPop   = ipPop & opValid;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign doPush  = ipPush & (~full | doPop);
   assign doDrop  = ipPush & full & ~doPop;

   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         count   <= '0;
         dropCnt <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + AW'(1);
         if (doPop)  rdPtr <= rdPtr + AW'(1);
         case ({doPush, doPop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (doDrop) dropCnt <= satInc16(dropCnt);
      end
   end

   always_ff @(posedge ipClk) begin
      if (doPush) mem[wrPtr] <= ipData;
   end

   // Storage is not reset, so an empty FIFO presents zero instead of stale data.
   assign opHead = opValid ? mem[rdPtr] : '0;
   assign opSize = count;
   assign opDrop = dropCnt;

endmodule

// File: rtl/pwm_demodulator.sv
// PWM capture: synchronises the pin, measures high time per period and
// rebuilds signed samples, falling back to constant-level samples on timeout.
module pwm_demodulator
   import pwm_demodulator_pkg::*;
#(
   parameter int DUTY_WIDTH = DUTY_WIDTH_DEF,
   parameter int TIMEOUT    = 512,
   parameter int FIFO_DEPTH = 16
)(
   input  logic                        ipClk,
   input  logic                        ipReset,
   input  logic                        ipPWM,
   pwm_demodulator_if.master           stream,
   output logic [$clog2(FIFO_DEPTH):0] opFIFO_Size,
   output logic [15:0]                 opDropCount,
   output logic                        opPeriodErr
);

   localparam int CW = DUTY_WIDTH + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] PERIOD   = CW'(2**DUTY_WIDTH);
   localparam logic [CW-1:0] DUTY_MAX = CW'(2**DUTY_WIDTH - 1);

   logic pwmSync_p0;
   logic pwmSync_p1;
   logic pwmLevel_p2;
   logic rise_p2;

   DEMOD_STATE state;
   DEMOD_STATE nextState;

   logic [CW-1:0]         periodCnt;
   logic [CW-1:0]         highCnt;
   logic [TW-1:0]         tmoCnt;
   logic [DUTY_WIDTH-1:0] constCnt;

   logic               pushReq;
   logic [7:0]         pushDuty;
   logic               periodErr;
   logic signed [15:0] sample;

   function automatic logic [CW-1:0] satIncCnt(input logic [CW-1:0] v);
      return (v == '1) ? v : v + CW'(1);
   endfunction

   function automatic logic [TW-1:0] satIncTmo(input logic [TW-1:0] v);
      return (v == '1) ? v : v + TW'(1);
   endfunction

   // Stage p0/p1: metastability synchroniser; p2: registered level and rising edge
   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         pwmSync_p0  <= 1'b0;
         pwmSync_p1  <= 1'b0;
         pwmLevel_p2 <= 1'b0;
         rise_p2     <= 1'b0;
      end else begin
         pwmSync_p0  <= ipPWM;
         pwmSync_p1  <= pwmSync_p0;
         pwmLevel_p2 <= pwmSync_p1;
         rise_p2     <= pwmSync_p1 & ~pwmLevel_p2;
      end
   end

   always_ff @(posedge ipClk) begin
      if (ipReset) state <= IDLE;
      else         state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE, MEASURE: begin
            if (rise_p2)                          nextState = MEASURE;
            else if (tmoCnt >= TW'(TIMEOUT - 1))  nextState = CONST;
         end
         CONST:   if (rise_p2) nextState = MEASURE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      pushReq   = 1'b0;
      pushDuty  = 8'h00;
      periodErr = 1'b0;
      case (state)
         MEASURE: begin
            if (rise_p2) begin
               pushReq   = 1'b1;
               pushDuty  = (highCnt > DUTY_MAX) ? 8'hFF : highCnt[7:0];
               periodErr = (periodCnt != PERIOD);
            end
         end
         CONST: begin
            if (!rise_p2 && constCnt == '0) begin
               pushReq  = 1'b1;
               pushDuty = pwmLevel_p2 ? 8'hFF : 8'h00;
            end
         end
         default: ;
      endcase
   end

   // A rising edge always restarts measurement at 1: the edge cycle itself is high.
   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         periodCnt <= '0;
         highCnt   <= '0;
         tmoCnt    <= '0;
         constCnt  <= '0;
      end else begin
         tmoCnt   <= rise_p2 ? TW'(1) : satIncTmo(tmoCnt);
         constCnt <= (state == CONST) ? constCnt + DUTY_WIDTH'(1) : '0;
         if (rise_p2) begin
            periodCnt <= CW'(1);
            highCnt   <= CW'(1);
         end else if (state == MEASURE) begin
            periodCnt <= satIncCnt(periodCnt);
            if (pwmLevel_p2) highCnt <= satIncCnt(highCnt);
         end else begin
            periodCnt <= '0;
            highCnt   <= '0;
         end
      end
   end

   assign sample      = DutyToSample(pushDuty);
   assign opPeriodErr = periodErr;

   sample_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (16)
   ) u_fifo (
      .ipClk   (ipClk),
      .ipReset (ipReset),
      .ipPush  (pushReq),
      .ipData  (sample),
      .ipPop   (stream.ipReady),
      .opHead  (stream.opStream),
      .opValid (stream.opValid),
      .opSize  (opFIFO_Size),
      .opDrop  (opDropCount)
   );

endmodule

// File: tb/tb_pwm_demodulator.sv
// Scoreboard bench for pwm_demodulator: a waveform-level model predicts the
// samples per period and a monitor compares each accepted output.
module tb_pwm_demodulator;
   import pwm_demodulator_pkg::*;

   localparam int TIMEOUT    = 512;
   localparam int FIFO_DEPTH = 16;

   logic ipClk   = 1'b0;
   logic ipReset = 1'b1;
   logic ipPWM   = 1'b0;
   logic [$clog2(FIFO_DEPTH):0] opFIFO_Size;
   logic [15:0] opDropCount;
   logic        opPeriodErr;

   pwm_demodulator_if sIf();

   pwm_demodulator #(
      .DUTY_WIDTH (8),
      .TIMEOUT    (TIMEOUT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .ipClk       (ipClk),
      .ipReset     (ipReset),
      .ipPWM       (ipPWM),
      .stream      (sIf),
      .opFIFO_Size (opFIFO_Size),
      .opDropCount (opDropCount),
      .opPeriodErr (opPeriodErr)
   );

   always #5 ipClk = ~ipClk;

   typedef struct {
      logic [15:0] data;
      bit          err;
   } exp_t;

   exp_t expQ[$];
   int   arrivals[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rstCyc = 0;
   int   errPulses = 0;
   int   expErrs = 0;
   int   expDrops = 0;
   bit   chkErr = 1'b1;
   bit   errPrev = 1'b0;
   bit   havePrev = 1'b0;
   int   prevH = 0;
   int   prevP = 0;

   always @(posedge ipClk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT hands over a sample.
   always @(negedge ipClk) begin
      exp_t e;
      if (ipReset) begin
         errPrev = 1'b0;
      end else begin
         if (sIf.opValid && sIf.ipReady) begin
            arrivals.push_back(cyc);
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_sample actual=%0h required=none", sIf.opStream);
            end else begin
               e = expQ.pop_front();
               check("sample", {16'h0, sIf.opStream}, {16'h0, e.data});
               if (chkErr) check("period_err_with_sample", {31'h0, errPrev}, {31'h0, e.err});
            end
         end
         if (opPeriodErr) errPulses++;
         errPrev = opPeriodErr;
      end
   end

   task automatic tick();
      @(posedge ipClk);
      #1;
   endtask

   // Reference: signed sample = (duty - 128) * 256, duty clipped to 255.
   task automatic pushExp(input int h, input int p);
      exp_t e;
      int duty;
      duty   = (h > 255) ? 255 : h;
      e.data = 16'((duty - 128) * 256);
      e.err  = (p != PWM_PERIOD);
      if (e.err) expErrs++;
      if (!sIf.ipReady && expQ.size() >= FIFO_DEPTH) expDrops++;
      else expQ.push_back(e);
   endtask

   task automatic pwmPeriod(input int h, input int l);
      if (havePrev) pushExp(prevH, prevP);
      ipPWM = 1'b1;
      repeat (h) tick();
      ipPWM = 1'b0;
      repeat (l) tick();
      prevH    = h;
      prevP    = h + l;
      havePrev = 1'b1;
   endtask

   task automatic finishEdge();
      if (havePrev) pushExp(prevH, prevP);
      ipPWM = 1'b1;
      repeat (10) tick();
      ipPWM = 1'b0;
      repeat (20) tick();
      havePrev = 1'b0;
   endtask

   task automatic doReset();
      ipPWM   = 1'b0;
      ipReset = 1'b1;
      sIf.ipReady = 1'b1;
      repeat (3) tick();
      expQ.delete();
      check("rst_valid",  {31'h0, sIf.opValid}, 32'h0);
      check("rst_stream", {16'h0, sIf.opStream}, 32'h0);
      check("rst_size",   32'(opFIFO_Size), 32'h0);
      check("rst_drop",   {16'h0, opDropCount}, 32'h0);
      check("rst_err",    {31'h0, opPeriodErr}, 32'h0);
      errPulses = 0;
      expErrs   = 0;
      expDrops  = 0;
      havePrev  = 1'b0;
      chkErr    = 1'b1;
      ipReset   = 1'b0;
      rstCyc    = cyc;
   endtask

   task automatic endTest(input string tag);
      repeat (20) tick();
      check({tag, "_leftover"}, expQ.size(), 0);
      check({tag, "_err_pulses"}, errPulses, expErrs);
      check({tag, "_drops"}, {16'h0, opDropCount}, expDrops);
   endtask

   initial begin
      sIf.ipReady = 1'b1;

      // Pin held low: timeout then one 0x8000 sample every period.
      doReset();
      arrivals.delete();
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         e.data = 16'h8000;
         e.err  = 1'b0;
         expQ.push_back(e);
      end
      repeat (1100) tick();
      check("const_count", arrivals.size(), 3);
      if (arrivals.size() == 3) begin
         checks++;
         if (arrivals[0] - rstCyc < TIMEOUT || arrivals[0] - rstCyc > TIMEOUT + 8) begin
            errors++;
            $display("FAIL const_first_push actual=%0d required=%0d..%0d",
                     arrivals[0] - rstCyc, TIMEOUT, TIMEOUT + 8);
         end
         check("const_spacing1", arrivals[1] - arrivals[0], PWM_PERIOD);
         check("const_spacing2", arrivals[2] - arrivals[1], PWM_PERIOD);
      end
      endTest("const_low");

      // Quarter duty.
      doReset();
      for (int i = 0; i < 4; i++) pwmPeriod(64, 192);
      finishEdge();
      endTest("duty40");

      // Half duty with one stretched period.
      doReset();
      for (int i = 0; i < 3; i++) pwmPeriod(128, 128);
      pwmPeriod(128, 172);
      pwmPeriod(128, 128);
      finishEdge();
      endTest("stretch");

      // Full duty.
      doReset();
      for (int i = 0; i < 4; i++) pwmPeriod(255, 1);
      finishEdge();
      endTest("dutyFF");

      // Random duties and occasional off-nominal periods.
      doReset();
      for (int i = 0; i < 8; i++) begin
         int p;
         int h;
         p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(200, 400)) : PWM_PERIOD;
         h = $urandom_range(1, p - 1);
         pwmPeriod(h, p - h);
      end
      finishEdge();
      endTest("random");

      // Stalled consumer: overflow, then drain in order.
      doReset();
      sIf.ipReady = 1'b0;
      chkErr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         int h;
         h = $urandom_range(1, 255);
         pwmPeriod(h, PWM_PERIOD - h);
      end
      finishEdge();
      repeat (10) tick();
      check("full_size", 32'(opFIFO_Size), FIFO_DEPTH);
      check("full_drops", {16'h0, opDropCount}, 4);
      sIf.ipReady = 1'b1;
      repeat (FIFO_DEPTH) tick();
      check("drained_valid", {31'h0, sIf.opValid}, 32'h0);
      check("drained_size", 32'(opFIFO_Size), 32'h0);
      endTest("overflow");

      // Reset mid-period with five samples buffered.
      doReset();
      sIf.ipReady = 1'b0;
      for (int i = 0; i < 5; i++) pwmPeriod(64, 192);
      pushExp(prevH, prevP);
      ipPWM = 1'b1;
      repeat (64) tick();
      ipPWM = 1'b0;
      repeat (50) tick();
      check("pre_reset_size", 32'(opFIFO_Size), 5);
      ipReset = 1'b1;
      tick();
      ipReset = 1'b0;
      expQ.delete();
      havePrev  = 1'b0;
      errPulses = 0;
      expErrs   = 0;
      check("midrst_valid",  {31'h0, sIf.opValid}, 32'h0);
      check("midrst_stream", {16'h0, sIf.opStream}, 32'h0);
      check("midrst_size",   32'(opFIFO_Size), 32'h0);
      check("midrst_drop",   {16'h0, opDropCount}, 32'h0);
      check("midrst_err",    {31'h0, opPeriodErr}, 32'h0);
      check("midrst_state",  32'(dut.state), 32'(IDLE));
      sIf.ipReady = 1'b1;
      pwmPeriod(64, 192);
      finishEdge();
      endTest("midreset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
